tone_selector: RTL and testbench

Consumes the eight note square waves from the piano clock manager and the raw piano keys, and drives the speaker pin. Keys are synchronized and debounced, and the lowest-index pressed key wins. A three-state FSM gates the selected tone onto SPEAKER with a release tail. Note changes only happen while the waves are low, so SPEAKER never carries a truncated pulse.

---
 rtl/piano_pkg.sv | 34 +++
 rtl/key_debouncer.sv | 32 +++
 rtl/tone_selector.sv | 138 +++++++++++++
 tb/tb_tone_selector.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// Shared piano definitions: note indices, note count, tone FSM states and
// a lowest-index priority helper.
package piano_pkg;

  localparam int N_NOTES = 8;

  localparam logic [2:0] NOTE_C4 = 3'd0;
  localparam logic [2:0] NOTE_D4 = 3'd1;
  localparam logic [2:0] NOTE_E4 = 3'd2;
  localparam logic [2:0] NOTE_F4 = 3'd3;
  localparam logic [2:0] NOTE_G4 = 3'd4;
  localparam logic [2:0] NOTE_A4 = 3'd5;
  localparam logic [2:0] NOTE_B4 = 3'd6;
  localparam logic [2:0] NOTE_C5 = 3'd7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    RELEASE = 2'd2
  } tone_state_e;

  // Lowest set bit wins; returns 0 for an empty vector.
  function automatic logic [2:0] lowest_set(input logic [N_NOTES-1:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = N_NOTES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Single-key debouncer: the stable value follows the synchronized key only
// after it has differed for DEBOUNCE_CYCLES consecutive cycles.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ksync,
  output logic stable
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_r;

  // Count consecutive differing cycles; accept the new level on the last one.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_r  <= '0;
      stable <= 1'b0;
    end else if (ksync == stable) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      stable <= ksync;
      cnt_r  <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/tone_selector.sv
// Piano tone selector: synchronizes and debounces the keys, picks the lowest
// pressed note and gates its square wave onto SPEAKER with a release tail.
module tone_selector
  import piano_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int RELEASE_CYCLES  = 25_000_000
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [N_NOTES-1:0]  KEY,
  input  logic [N_NOTES-1:0]  NOTE_CLK,
  output logic                SPEAKER,
  output logic [2:0]          NOTE_IDX,
  output logic                PLAYING,
  output logic [N_NOTES-1:0]  LED
);

  localparam int RW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [RW-1:0] REL_LOAD = RW'(RELEASE_CYCLES - 1);

  logic [N_NOTES-1:0] key_meta_r;
  logic [N_NOTES-1:0] key_sync_r;
  logic [N_NOTES-1:0] stable_s;
  logic               req_valid_s;
  logic [2:0]         req_idx_s;

  tone_state_e state_r, state_n;
  logic [2:0]    cur_idx_r, cur_idx_n;
  logic [2:0]    pend_idx_r, pend_idx_n;
  logic [RW-1:0] rel_cnt_r, rel_cnt_n;

  // Two-flop synchronizer for the asynchronous key inputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      key_meta_r <= '0;
      key_sync_r <= '0;
    end else begin
      key_meta_r <= KEY;
      key_sync_r <= key_meta_r;
    end
  end

  for (genvar g = 0; g < N_NOTES; g++) begin : g_deb
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .CLK   (CLK),
      .RESET (RESET),
      .ksync (key_sync_r[g]),
      .stable(stable_s[g])
    );
  end

  assign req_valid_s = |stable_s;
  assign req_idx_s   = lowest_set(stable_s);

  // Tone FSM next-state, note switching and release countdown.
  always_comb begin
    state_n    = state_r;
    cur_idx_n  = cur_idx_r;
    pend_idx_n = pend_idx_r;
    rel_cnt_n  = rel_cnt_r;

    // Switch notes only while both waves are low so no pulse is cut short.
    if ((state_r != IDLE) && (pend_idx_r != cur_idx_r) &&
        !NOTE_CLK[cur_idx_r] && !NOTE_CLK[pend_idx_r]) begin
      cur_idx_n = pend_idx_r;
    end else begin
      cur_idx_n = cur_idx_r;
    end

    case (state_r)
      IDLE: begin
        // pend_idx is aligned too, so a stale pending note cannot steal the start.
        if (req_valid_s && !NOTE_CLK[req_idx_s]) begin
          cur_idx_n  = req_idx_s;
          pend_idx_n = req_idx_s;
          state_n    = PLAY;
        end else begin
          state_n = IDLE;
        end
      end
      PLAY: begin
        if (req_valid_s) begin
          pend_idx_n = req_idx_s;
        end else begin
          rel_cnt_n = REL_LOAD;
          state_n   = RELEASE;
        end
      end
      RELEASE: begin
        if (req_valid_s) begin
          pend_idx_n = req_idx_s;
          state_n    = PLAY;
        end else if (rel_cnt_r != '0) begin
          rel_cnt_n = rel_cnt_r - RW'(1);
        end else if (!NOTE_CLK[cur_idx_r]) begin
          state_n = IDLE;
        end else begin
          state_n = RELEASE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // FSM state registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r    <= IDLE;
      cur_idx_r  <= 3'd0;
      pend_idx_r <= 3'd0;
      rel_cnt_r  <= '0;
    end else begin
      state_r    <= state_n;
      cur_idx_r  <= cur_idx_n;
      pend_idx_r <= pend_idx_n;
      rel_cnt_r  <= rel_cnt_n;
    end
  end

  // Registered outputs; PLAYING and NOTE_IDX track the state being entered.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      SPEAKER  <= 1'b0;
      NOTE_IDX <= 3'd0;
      PLAYING  <= 1'b0;
      LED      <= '0;
    end else begin
      SPEAKER  <= (state_r != IDLE) & NOTE_CLK[cur_idx_r];
      NOTE_IDX <= cur_idx_n;
      PLAYING  <= (state_n != IDLE);
      LED      <= stable_s;
    end
  end

endmodule

// File: tb/tb_tone_selector.sv
// Self-checking bench for tone_selector: vector table, directed corner
// sequences and random key activity against an event-level reference model.
module tb_tone_selector;

  localparam int DEB = 4;
  localparam int REL = 8;

  logic       clk;
  logic       rst;
  logic [7:0] key;
  logic [7:0] note_clk;
  logic       speaker;
  logic [2:0] note_idx;
  logic       playing;
  logic [7:0] led;

  tone_selector #(.DEBOUNCE_CYCLES(DEB), .RELEASE_CYCLES(REL)) dut (
    .CLK     (clk),
    .RESET   (rst),
    .KEY     (key),
    .NOTE_CLK(note_clk),
    .SPEAKER (speaker),
    .NOTE_IDX(note_idx),
    .PLAYING (playing),
    .LED     (led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out, expected event never seen (t=%0t)", name, $time);
  endtask

  // Note waves: note i has half-period 3+i cycles and a random phase.
  int cyc;
  int half [8];
  int ofs  [8];

  function automatic logic [7:0] wave(input int c);
    logic [7:0] w;
    for (int i = 0; i < 8; i++) w[i] = (((c + ofs[i]) / half[i]) % 2) == 1;
    return w;
  endfunction

  // Reference model: keys delayed two edges, a key level is accepted once the
  // last DEB delayed samples all disagree with it; release tail is a deadline.
  logic [7:0] m_kp1, m_kp2;
  logic [7:0] m_hist [DEB];
  logic [7:0] m_stable;
  int m_state;  // 0 silent, 1 held, 2 tail
  int m_cur, m_pend, m_rel_end, m_edge;
  logic       exp_spk, exp_play;
  logic [2:0] exp_idx;
  logic [7:0] exp_led;

  function automatic int lowest_idx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_edge(input logic [7:0] k, input logic [7:0] nc, input logic r);
    logic [7:0] nst;
    bit all_diff, rv;
    int ri, ncur, npend, nstate;
    if (r) begin
      m_kp1 = 8'h00; m_kp2 = 8'h00; m_stable = 8'h00;
      for (int i = 0; i < DEB; i++) m_hist[i] = 8'h00;
      m_state = 0; m_cur = 0; m_pend = 0; m_rel_end = 0; m_edge = 0;
      exp_spk = 1'b0; exp_play = 1'b0; exp_idx = 3'd0; exp_led = 8'h00;
    end else begin
      m_edge++;
      for (int i = DEB - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = m_kp2;
      nst = m_stable;
      for (int b = 0; b < 8; b++) begin
        all_diff = 1'b1;
        for (int i = 0; i < DEB; i++) if (m_hist[i][b] == m_stable[b]) all_diff = 1'b0;
        if (all_diff) nst[b] = ~m_stable[b];
      end
      rv = (m_stable != 8'h00);
      ri = lowest_idx(m_stable);
      exp_spk = (m_state != 0) && nc[m_cur];
      ncur = m_cur; npend = m_pend; nstate = m_state;
      if (m_state != 0 && m_pend != m_cur && !nc[m_cur] && !nc[m_pend]) ncur = m_pend;
      if (m_state == 0) begin
        if (rv && !nc[ri]) begin ncur = ri; npend = ri; nstate = 1; end
      end else if (m_state == 1) begin
        if (rv) npend = ri;
        else begin nstate = 2; m_rel_end = m_edge + REL; end
      end else begin
        if (rv) begin npend = ri; nstate = 1; end
        else if (m_edge >= m_rel_end && !nc[m_cur]) nstate = 0;
      end
      exp_led  = m_stable;
      m_stable = nst;
      m_state  = nstate; m_cur = ncur; m_pend = npend;
      exp_play = (m_state != 0);
      exp_idx  = 3'(m_cur);
      m_kp2 = m_kp1;
      m_kp1 = k;
    end
  endtask

  logic       prev_spk, prev_play, run_valid;
  logic [2:0] prev_idx;
  int         run_len, run_note;

  // One clock: model on the rising edge, compare on the falling edge.
  task automatic step();
    logic [7:0] nc_edge;
    @(posedge clk);
    nc_edge = note_clk;
    model_edge(key, note_clk, rst);
    @(negedge clk);
    chk("speaker", speaker, exp_spk);
    chk("note_idx", note_idx, exp_idx);
    chk("playing", playing, exp_play);
    chk("led", led, exp_led);
    if (rst) begin
      run_valid = 1'b0;
    end else begin
      if (prev_play && playing && note_idx != prev_idx) begin
        chk("switch_old_low", nc_edge[prev_idx], 32'd0);
        chk("switch_new_low", nc_edge[note_idx], 32'd0);
      end
      if (speaker && !prev_spk) begin
        run_valid = 1'b1; run_len = 0; run_note = prev_idx;
      end
      if (speaker) run_len++;
      else if (prev_spk && run_valid) begin
        chk("pulse_len", run_len, half[run_note]);
        run_valid = 1'b0;
      end
    end
    prev_spk = speaker; prev_idx = note_idx; prev_play = playing;
    cyc++;
    note_clk = wave(cyc);
  endtask

  typedef struct {
    logic [7:0] key;
    int         hold;
    logic [7:0] exp_led;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int n, drops, hi_cnt;
    logic [7:0] rk;

    vecs[0] = '{8'hFF, 6,  8'h00};
    vecs[1] = '{8'hFF, 1,  8'hFF};
    vecs[2] = '{8'h0F, 3,  8'hFF};
    vecs[3] = '{8'hFF, 10, 8'hFF};
    vecs[4] = '{8'h01, 7,  8'h01};
    vecs[5] = '{8'h81, 6,  8'h01};
    vecs[6] = '{8'h81, 1,  8'h81};

    for (int i = 0; i < 8; i++) begin
      half[i] = 3 + i;
      ofs[i]  = $urandom_range(0, 19);
    end
    cyc = 0;
    note_clk = wave(0);
    prev_spk = 1'b0; prev_play = 1'b0; prev_idx = 3'd0; run_valid = 1'b0;
    run_len = 0; run_note = 0;

    // Reset with all keys held.
    rst = 1'b1;
    key = 8'hFF;
    repeat (3) step();
    chk("rst_speaker", speaker, 32'd0);
    chk("rst_playing", playing, 32'd0);
    chk("rst_led", led, 32'd0);
    chk("rst_note_idx", note_idx, 32'd0);
    rst = 1'b0;

    // Debounce latency and short-glitch table.
    for (int i = 0; i < 7; i++) begin
      key = vecs[i].key;
      repeat (vecs[i].hold) step();
      chk($sformatf("vec%0d_led", i), led, vecs[i].exp_led);
    end

    // Bounce on KEY[2]: four 3-cycle toggles, the fifth edge is held.
    for (int t = 0; t < 4; t++) begin
      key[2] = ~key[2];
      repeat (3) begin
        step();
        chk("bounce_led2", led[2], 32'd0);
      end
    end
    key[2] = 1'b1;
    repeat (6) begin
      step();
      chk("bounce_hold_led2", led[2], 32'd0);
    end
    step();
    chk("bounce_final_led2", led[2], 32'd1);

    // Back to silence.
    key = 8'h00;
    n = 0;
    do begin step(); n++; end while ((playing || n < 10) && n < 200);
    if (playing) timeout_fail("idle_wait");

    // Priority and note switch: 4 first, then 1 wins.
    key = 8'h10;
    n = 0;
    do begin step(); n++; end while (!playing && n < 200);
    if (!playing) timeout_fail("press4_wait");
    chk("press4_idx", note_idx, 32'd4);
    repeat (20) step();
    key = 8'h12;
    n = 0;
    do begin step(); n++; end while (note_idx != 3'd1 && n < 300);
    if (note_idx != 3'd1) timeout_fail("switch1_wait");
    chk("switch1_idx", note_idx, 32'd1);

    // Re-press KEY[7] so it is seen while the release count is at 3.
    key = 8'h00;
    repeat (5) step();
    key = 8'h80;
    drops = 0;
    n = 0;
    do begin
      step(); n++;
      if (!playing) drops++;
    end while (note_idx != 3'd7 && n < 300);
    if (note_idx != 3'd7) timeout_fail("repress_wait");
    chk("repress_no_drop", drops, 32'd0);
    chk("repress_idx", note_idx, 32'd7);
    repeat (10) step();

    // Release tail.
    key = 8'h00;
    hi_cnt = 0;
    n = 0;
    do begin
      step(); n++;
      if (playing) hi_cnt++;
    end while (playing && n < 300);
    if (playing) timeout_fail("tail_wait");
    chk("tail_min_len", (hi_cnt >= 14) ? 32'd1 : 32'd0, 32'd1);
    repeat (5) begin
      step();
      chk("tail_speaker_quiet", speaker, 32'd0);
    end

    // Mid-note asynchronous reset.
    key = 8'h08;
    n = 0;
    do begin step(); n++; end while (!speaker && n < 300);
    if (!speaker) timeout_fail("speaker_high_wait");
    #2 rst = 1'b1;
    #1;
    chk("async_rst_speaker", speaker, 32'd0);
    chk("async_rst_playing", playing, 32'd0);
    repeat (2) step();
    rst = 1'b0;
    repeat (6) begin
      step();
      chk("post_rst_led_wait", led, 32'd0);
    end
    step();
    chk("post_rst_led", led, 32'h08);

    // Random key activity: holds, bounces and long silences.
    for (int s = 0; s < 80; s++) begin
      n = $urandom_range(0, 9);
      if (n < 2) begin
        key = 8'h00;
        repeat ($urandom_range(10, 30)) step();
      end else if (n < 4) begin
        rk = 8'($urandom);
        key = rk;
        repeat ($urandom_range(1, 3)) step();
      end else begin
        rk = 8'h01 << $urandom_range(0, 7);
        if ($urandom_range(0, 1) == 1) rk = rk | (8'h01 << $urandom_range(0, 7));
        key = rk;
        repeat ($urandom_range(5, 25)) step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
